// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle control unit: state codes, ALU ops,
// opcodes, function codes and datapath select values.
package mc_ctrl_pkg;

    localparam logic [3:0] ST_FETCH  = 4'd0;
    localparam logic [3:0] ST_DECODE = 4'd1;
    localparam logic [3:0] ST_EXEC_R = 4'd2;
    localparam logic [3:0] ST_RWB    = 4'd3;
    localparam logic [3:0] ST_ADDR   = 4'd4;
    localparam logic [3:0] ST_MRD    = 4'd5;
    localparam logic [3:0] ST_MWB    = 4'd6;
    localparam logic [3:0] ST_MWR    = 4'd7;
    localparam logic [3:0] ST_BRANCH = 4'd8;
    localparam logic [3:0] ST_JUMP   = 4'd9;
    localparam logic [3:0] ST_TRAP   = 4'd10;

    typedef enum logic [3:0] {
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC_R = ST_EXEC_R,
        S_RWB    = ST_RWB,
        S_ADDR   = ST_ADDR,
        S_MRD    = ST_MRD,
        S_MWB    = ST_MWB,
        S_MWR    = ST_MWR,
        S_BRANCH = ST_BRANCH,
        S_JUMP   = ST_JUMP,
        S_TRAP   = ST_TRAP
    } state_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type function field to ALU operation decoder; purely combinational.
// valid_o low flags an unsupported function code (alu_op_o then defaults to ADD).
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int FUNC_W = 6
) (
    input  logic [FUNC_W-1:0] func_i,
    output logic [2:0]        alu_op_o,
    output logic              valid_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        valid_o  = 1'b1;
        case (func_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_SLT:  alu_op_o = ALU_SLT;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU control: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory ready stall.
// Outputs are decoded from state; all outputs are forced to reset values while rst_n is low.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W   = 6,
    parameter int FUNC_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FUNC_W-1:0] func,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic              iord,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_src,
    output logic              reg_we,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [2:0]        alu_op,
    output logic              illegal,
    output logic [3:0]        state_o
);

    state_e     state_q, state_d;
    logic [2:0] fn_alu_op;
    logic       fn_valid;

    mc_alu_dec #(.FUNC_W(FUNC_W)) u_alu_dec (
        .func_i   (func),
        .alu_op_o (fn_alu_op),
        .valid_o  (fn_valid)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: state_d = fn_valid ? S_RWB : S_TRAP;
            S_RWB:    state_d = S_FETCH;
            S_ADDR:   state_d = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD:    if (mem_ready) state_d = S_MWB;
            S_MWB:    state_d = S_FETCH;
            S_MWR:    if (mem_ready) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Gating on rst_n lets an asserted reset drop the FETCH memory request immediately.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ALU;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                end
                S_DECODE: alu_src_b = SRCB_IMM_SH;
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = fn_alu_op;
                end
                S_RWB: begin
                    reg_we  = 1'b1;
                    reg_dst = 1'b1;
                end
                S_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MWB: begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_we     = zero;
                end
                S_JUMP: begin
                    pc_src = PCSRC_JUMP;
                    pc_we  = 1'b1;
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed cases followed by random instruction streams,
// each cycle compared against a per-instruction expected-output sequence.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
    logic       alu_src_a, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal), .state_o(state_o)
    );

    typedef struct packed {
        logic       mem_req, mem_we, iord, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       reg_we, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal;
        logic [3:0] state;
    } obs_t;

    obs_t obs;
    assign obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, illegal, state_o};

    // Idle datapath: no strobes, selects zero, ALU adding.
    function automatic obs_t idle(input logic [3:0] st);
        obs_t e = '0;
        e.alu_op = 3'b010;
        e.state  = st;
        return e;
    endfunction

    function automatic obs_t fetch_exp(input logic mr);
        obs_t e = idle(S_FETCH);
        e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.ir_we = mr; e.pc_we = mr;
        return e;
    endfunction

    // Returns {supported, alu_op} for an R-type function code.
    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b1_010;
            6'h22:   return 4'b1_110;
            6'h24:   return 4'b1_000;
            6'h25:   return 4'b1_001;
            6'h2A:   return 4'b1_111;
            default: return 4'b0_010;
        endcase
    endfunction

    task automatic check(input obs_t e, input string tag);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, e);
        end
    endtask

    // Called mid-cycle: drive inputs, check this cycle's outputs, advance one cycle.
    task automatic step(input obs_t e, input logic mr, input logic z, input string tag);
        mem_ready = mr;
        zero      = z;
        #1;
        check(e, tag);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check(idle(S_FETCH), "rst_async");
        @(negedge clk);
        #1;
        check(idle(S_FETCH), "rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic trap_and_reset();
        for (int i = 0; i < 20; i++) begin
            obs_t e = idle(S_TRAP);
            e.illegal = 1'b1;
            step(e, 1'($urandom), 1'($urandom), "trap");
        end
        do_reset();
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fs, input int ms, input logic z);
        obs_t e;
        logic [3:0] a;
        opcode = op;
        func   = fn;
        for (int i = 0; i < fs; i++) step(fetch_exp(1'b0), 1'b0, z, "fetch_wait");
        step(fetch_exp(1'b1), 1'b1, z, "fetch");
        e = idle(S_DECODE); e.alu_src_b = 2'b11;
        step(e, 1'($urandom), z, "decode");
        case (op)
            6'h00: begin
                a = alu_of(fn);
                e = idle(S_EXEC_R); e.alu_src_a = 1'b1; e.alu_op = a[2:0];
                step(e, 1'($urandom), z, "exec_r");
                if (a[3]) begin
                    e = idle(S_RWB); e.reg_we = 1'b1; e.reg_dst = 1'b1;
                    step(e, 1'($urandom), z, "rwb");
                end else begin
                    trap_and_reset();
                end
            end
            6'h23, 6'h2B: begin
                e = idle(S_ADDR); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                step(e, 1'($urandom), z, "addr");
                e = idle(op == 6'h23 ? S_MRD : S_MWR);
                e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (op == 6'h2B);
                for (int i = 0; i < ms; i++) step(e, 1'b0, z, "mem_wait");
                step(e, 1'b1, z, "mem");
                if (op == 6'h23) begin
                    e = idle(S_MWB); e.reg_we = 1'b1; e.mem_to_reg = 1'b1;
                    step(e, 1'($urandom), z, "mwb");
                end
            end
            6'h04: begin
                e = idle(S_BRANCH); e.alu_src_a = 1'b1; e.alu_op = 3'b110;
                e.pc_src = 2'b01; e.pc_we = z;
                step(e, 1'($urandom), z, "branch");
            end
            6'h02: begin
                e = idle(S_JUMP); e.pc_src = 2'b10; e.pc_we = 1'b1;
                step(e, 1'($urandom), z, "jump");
            end
            default: trap_and_reset();
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [5];
        logic [5:0] fns [5];
        obs_t e;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        @(negedge clk);
        #1;
        check(idle(S_FETCH), "reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        run_instr(6'h00, 6'h20, 0, 0, 1'b0);   // add
        run_instr(6'h23, 6'h20, 0, 3, 1'b0);   // lw with 3 wait cycles
        run_instr(6'h04, 6'h00, 0, 0, 1'b1);   // beq taken
        run_instr(6'h04, 6'h00, 0, 0, 1'b0);   // beq not taken
        run_instr(6'h2B, 6'h00, 2, 1, 1'b0);   // sw
        run_instr(6'h3F, 6'h00, 0, 0, 1'b0);   // illegal opcode
        run_instr(6'h00, 6'h27, 1, 0, 1'b0);   // illegal func
        run_instr(6'h02, 6'h00, 0, 0, 1'b0);   // j

        // Reset while stalled in MWR.
        opcode = 6'h2B;
        step(fetch_exp(1'b1), 1'b1, 1'b0, "fetch");
        e = idle(S_DECODE); e.alu_src_b = 2'b11;
        step(e, 1'b0, 1'b0, "decode");
        e = idle(S_ADDR); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        step(e, 1'b0, 1'b0, "addr");
        e = idle(S_MWR); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1;
        step(e, 1'b0, 1'b0, "mwr_wait");
        step(e, 1'b0, 1'b0, "mwr_wait");
        #2;
        do_reset();
        run_instr(6'h00, 6'h2A, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            op = ops[$urandom_range(0, 4)];
            fn = fns[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) op = 6'($urandom_range(5, 63));
                else begin op = 6'h00; fn = 6'($urandom); end
            end
            run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
